ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised control-word pipeline: carries a decoded control word from decode through NSTAGES pipeline registers, e.g. E, M, W for NSTAGES=3.
- Successor to the fixed hand-wired D->E->M->W control registers.
- Adds per-stage valid bits, per-stage stall with upstream propagation, per-stage flush, and per-stage field pruning.
- Sits between main/ALU decoders and the datapath; the datapath consumes the per-stage control outputs directly.

Parameters:
- CW, 16, control word width in bits.
- NSTAGES, 3, number of pipeline registers (stage 0 is fed from decode).
- KEEP_MASK, all ones (NSTAGES*CW bits), bit [i*CW+b]=1 means field bit b is carried in stage i; 0 means the bit is held at 0 in that stage.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset on the next rising clk).
- in_valid  in  1  decode-stage word valid.
- in_ctrl  in  CW  decode-stage control word.
- in_ready  out  1  stage 0 can accept this cycle.
- stall  in  NSTAGES  stall[i]=1 holds stage i.
- flush  in  NSTAGES  flush[i]=1 turns stage i into a bubble.
- stage_valid  out  NSTAGES  valid bit of each stage register.
- stage_ctrl  out  NSTAGES*CW  stage i word at bits [i*CW +: CW].

Behaviour:
- Reset (reset=0 at an edge): every stage_valid=0 and every stage_ctrl=0. Reset overrides stall and flush. Reset mid-stream discards all in-flight words. in_ready is combinational and equals ~hold[0], so it is 1 during reset unless stall is asserted.
- Hold chain (combinational): hold[NSTAGES-1]=stall[NSTAGES-1]; hold[i]=stall[i] | hold[i+1].
  - A stall at stage k therefore freezes stages 0..k.
- Per-stage update at each rising edge, in priority order:
  1. reset=0: clear the stage.
  2. flush[i]=1: load a bubble (valid=0, ctrl=0). This applies even when hold[i]=1, i.e. flush beats stall.
  3. hold[i]=1: keep the current contents.
  4. Otherwise load from upstream:
     - i>0 and hold[i-1]=1: load a bubble (stall boundary inserts one bubble).
     - i>0 otherwise: load stage i-1 contents.
     - i=0: load {in_valid, in_ctrl}.
- Masking: the loaded ctrl is ANDed with the stage's KEEP_MASK slice. Masked bits are constant 0; synthesis prunes them.
- Bubble invariant: any stage with valid=0 presents ctrl=0, so regwrite/memwrite-type fields are never asserted by a bubble. A word with in_valid=0 is loaded as all-zero ctrl.
- Handshake: a word is accepted when in_valid & in_ready. When in_ready=0, decode must hold in_ctrl stable; the block does not sample it.
- Latency: an accepted word appears at stage i output i+1 cycles later when there are no stalls. Each stall cycle at or downstream of a word adds 1 cycle.
- Simultaneous flush[i] and stall[j] with j>i: stage i becomes a bubble, stages 0..i-1 hold, and stage i then remains held until the stall clears.
- No combinational path from in_ctrl to any output.

Optional Feature:
- Macro CTRL_PIPE_PERF_EN.
- Defined: adds output ports perf_stall_cnt (32 bits) and perf_bubble_cnt (32 bits).
  - perf_stall_cnt increments each cycle in which hold[0]=1.
  - perf_bubble_cnt increments each cycle in which stage NSTAGES-1 loads a bubble.
  - Both wrap at 2^32 and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package ctrl_pipe_pkg holds:
  - typedef ctrl_word_t (CW bits);
  - localparams for standard field bit positions (REGWRITE, MEMTOREG, MEMWRITE[1:0], ALUCTRL[3:0], ALUSRC[1:0], REGDST, READTYPE[2:0]);
  - default KEEP_MASK constants for the 3-stage E/M/W configuration.
- One natural sub-module, ctrl_pipe_stage: a single register with flush/hold/load/mask, instantiated NSTAGES times in a generate loop.
- The hold chain stays in the top level.

Test Plan:
- Reset/flow: reset=0 for 2 cycles, then feed words 0x0011, 0x0022, 0x0033 on consecutive cycles (NSTAGES=3, CW=16, mask all ones) -> all outputs 0 during reset; 0x0011 appears at stage 0, 1 and 2 on cycles 1, 2 and 3 after acceptance; stage_valid=3'b111 by cycle 3.
- Stall propagation: with 0xA0A0 in stage 1, assert stall[1] for 2 cycles -> in_ready=0; stages 0 and 1 hold; stage 2 shows two bubbles (valid=0, ctrl=0x0000); flow resumes with no word lost or duplicated.
- Flush vs stall: assert flush[0] and stall[0] together with 0x5555 in stage 0 -> next cycle stage 0 valid=0, ctrl=0x0000; 0x5555 never reaches stage 1.
- Masking: KEEP_MASK stage-2 slice = 0x00FF, feed 0xABCD -> stage 0 and 1 show 0xABCD; stage 2 shows 0x00CD.
- Reset mid-operation: all stages valid and stall[2]=1, then reset=0 for one edge -> all stage_valid=0 and all ctrl=0 next cycle; in_ready follows ~hold[0].
- CTRL_PIPE_PERF_EN defined: 3 cycles of stall[0] plus 1 flush[2] -> perf_stall_cnt=3; perf_bubble_cnt counts stage-2 bubble loads exactly; both read 0 after reset.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and field layout for the decode-to-writeback control pipeline.
// Default KEEP masks describe the classic 3-stage E/M/W configuration.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 16;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  // Standard control-word field positions
  localparam int REGWRITE    = 0;
  localparam int MEMTOREG    = 1;
  localparam int MEMWRITE_LO = 2;
  localparam int MEMWRITE_HI = 3;
  localparam int ALUCTRL_LO  = 4;
  localparam int ALUCTRL_HI  = 7;
  localparam int ALUSRC_LO   = 8;
  localparam int ALUSRC_HI   = 9;
  localparam int REGDST      = 10;
  localparam int READTYPE_LO = 11;
  localparam int READTYPE_HI = 13;

  // E needs every field; M keeps memory and writeback fields; W keeps writeback only.
  localparam ctrl_word_t KEEP_E = 16'h3FFF;
  localparam ctrl_word_t KEEP_M = 16'h380F;
  localparam ctrl_word_t KEEP_W = 16'h0003;

  localparam logic [3*CTRL_W-1:0] KEEP_EMW = {KEEP_W, KEEP_M, KEEP_E};

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: flush beats hold, hold beats load.
// Loaded words are masked so unused fields stay constant 0 and get pruned.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int              CW   = CTRL_W,
  parameter logic [CW-1:0]   KEEP = {CW{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          up_bubble,
  input  logic          up_valid,
  input  logic [CW-1:0] up_ctrl,
  output logic          valid,
  output logic [CW-1:0] ctrl
);

  logic          valid_d, valid_q;
  logic [CW-1:0] ctrl_d,  ctrl_q;

  // Next-state selection; an invalid word is always loaded as all-zero ctrl
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = {CW{1'b0}};
    end else if (hold) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
    end else if (up_bubble) begin
      valid_d = 1'b0;
      ctrl_d  = {CW{1'b0}};
    end else begin
      valid_d = up_valid;
      ctrl_d  = up_valid ? (up_ctrl & KEEP) : {CW{1'b0}};
    end
  end

  // Stage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CW{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-word pipeline with valid, stall, flush and field pruning.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                    CW        = CTRL_W,
  parameter int                    NSTAGES   = 3,
  parameter logic [NSTAGES*CW-1:0] KEEP_MASK = {(NSTAGES*CW){1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_ctrl,
  output logic                    in_ready,
  input  logic [NSTAGES-1:0]      stall,
  input  logic [NSTAGES-1:0]      flush,
  output logic [NSTAGES-1:0]      stage_valid,
  output logic [NSTAGES*CW-1:0]   stage_ctrl
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_bubble_cnt
`endif
);

  logic [NSTAGES-1:0] hold_s;
  logic [NSTAGES-1:0] up_valid_s;
  logic [NSTAGES-1:0] up_bubble_s;
  logic [CW-1:0]      up_ctrl_s [NSTAGES];

  // A stall freezes its own stage and everything upstream of it
  always_comb begin
    hold_s            = {NSTAGES{1'b0}};
    hold_s[NSTAGES-1] = stall[NSTAGES-1];
    for (int i = NSTAGES - 2; i >= 0; i--) begin
      hold_s[i] = stall[i] | hold_s[i+1];
    end
  end

  assign in_ready = ~hold_s[0];

  for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid_s[i]  = in_valid;
      assign up_ctrl_s[i]   = in_ctrl;
      assign up_bubble_s[i] = 1'b0;
    end else begin : g_body
      assign up_valid_s[i]  = stage_valid[i-1];
      assign up_ctrl_s[i]   = stage_ctrl[(i-1)*CW +: CW];
      assign up_bubble_s[i] = hold_s[i-1];
    end

    ctrl_pipe_stage #(
      .CW   (CW),
      .KEEP (KEEP_MASK[i*CW +: CW])
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[i]),
      .hold      (hold_s[i]),
      .up_bubble (up_bubble_s[i]),
      .up_valid  (up_valid_s[i]),
      .up_ctrl   (up_ctrl_s[i]),
      .valid     (stage_valid[i]),
      .ctrl      (stage_ctrl[i*CW +: CW])
    );
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_d,  stall_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic        last_bubble_s;

  // Last stage loads a bubble on flush, or on a non-held load of an empty slot
  always_comb begin
    last_bubble_s = flush[NSTAGES-1] |
                    (~hold_s[NSTAGES-1] &
                     (up_bubble_s[NSTAGES-1] | ~up_valid_s[NSTAGES-1]));
    stall_cnt_d   = stall_cnt_q  + {31'd0, hold_s[0]};
    bubble_cnt_d  = bubble_cnt_q + {31'd0, last_bubble_s};
  end

  // Free-running wrap-around counters, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a full-mask instance and one with stage 2 pruned to 0x00FF.
// Counter checks are compiled in when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe;

  localparam int CW = 16;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;

  logic             in_ready,  m_in_ready;
  logic [NS-1:0]    valid,     m_valid;
  logic [NS*CW-1:0] ctrl,      m_ctrl;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] p_stall, p_bubble, m_p_stall, m_p_bubble;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.CW(CW), .NSTAGES(NS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .stage_valid(valid), .stage_ctrl(ctrl)
`ifdef CTRL_PIPE_PERF_EN
    , .perf_stall_cnt(p_stall), .perf_bubble_cnt(p_bubble)
`endif
  );

  ctrl_pipe #(.CW(CW), .NSTAGES(NS), .KEEP_MASK(48'h00FF_FFFF_FFFF)) dut_mask (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(m_in_ready), .stall(stall), .flush(flush),
    .stage_valid(m_valid), .stage_ctrl(m_ctrl)
`ifdef CTRL_PIPE_PERF_EN
    , .perf_stall_cnt(m_p_stall), .perf_bubble_cnt(m_p_bubble)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_ctrl = 16'h0000;
    stall = 3'b000; flush = 3'b000;

    // Reset for two edges
    tick(); tick();
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_ctrl",  64'(ctrl),  64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);

    // Flow: three words on consecutive cycles
    reset = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0011;
    tick();
    chk("flow1_s0", 64'(ctrl[15:0]), 64'h0011);
    chk("flow1_v",  64'(valid), 64'h1);
    in_ctrl = 16'h0022;
    tick();
    chk("flow2_s1", 64'(ctrl[31:16]), 64'h0011);
    in_ctrl = 16'h0033;
    tick();
    chk("flow3_v",    64'(valid), 64'h7);
    chk("flow3_ctrl", 64'(ctrl), 64'h0011_0022_0033);
    chk("flow3_mask", 64'(m_ctrl), 64'h0011_0022_0033);

    // Stall at stage 1 with 0xA0A0 resident there
    in_ctrl = 16'hA0A0; tick();
    in_ctrl = 16'hB0B0; tick();
    chk("pre_stall", 64'(ctrl), 64'h0033_A0A0_B0B0);
    stall = 3'b010; in_ctrl = 16'hC0C0;
    #1;
    chk("stall_ready", 64'(in_ready), 64'h0);
    tick();
    chk("stall1_v",    64'(valid), 64'h3);
    chk("stall1_ctrl", 64'(ctrl), 64'h0000_A0A0_B0B0);
    tick();
    chk("stall2_v",    64'(valid), 64'h3);
    chk("stall2_ctrl", 64'(ctrl), 64'h0000_A0A0_B0B0);
    stall = 3'b000;
    #1;
    chk("unstall_ready", 64'(in_ready), 64'h1);
    tick();
    chk("resume1_v",    64'(valid), 64'h7);
    chk("resume1_ctrl", 64'(ctrl), 64'hA0A0_B0B0_C0C0);
    in_valid = 1'b0; in_ctrl = 16'h1234;
    tick();
    chk("resume2_v",    64'(valid), 64'h6);
    chk("resume2_ctrl", 64'(ctrl), 64'hB0B0_C0C0_0000);
    tick();
    chk("resume3_ctrl", 64'(ctrl), 64'hC0C0_0000_0000);

    // Flush and stall together at stage 0
    in_valid = 1'b1; in_ctrl = 16'h5555;
    tick();
    chk("fs_load", 64'(ctrl[15:0]), 64'h5555);
    flush = 3'b001; stall = 3'b001; in_valid = 1'b0;
    tick();
    chk("fs_v",    64'(valid), 64'h0);
    chk("fs_ctrl", 64'(ctrl), 64'h0);
    flush = 3'b000; stall = 3'b000;
    tick();
    chk("fs_after", 64'({valid, ctrl}), 64'h0);

    // Masking: stage 2 of the pruned instance keeps only the low byte
    in_valid = 1'b1; in_ctrl = 16'hABCD;
    tick();
    chk("mask_s0", 64'(m_ctrl[15:0]), 64'hABCD);
    in_valid = 1'b0;
    tick();
    chk("mask_s1", 64'(m_ctrl[31:16]), 64'hABCD);
    tick();
    chk("mask_s2",   64'(m_ctrl[47:32]), 64'h00CD);
    chk("mask_full", 64'(ctrl[47:32]),   64'hABCD);
    chk("mask_v",    64'(m_valid), 64'h4);

    // Reset mid-stream while stage 2 is stalled
    in_valid = 1'b1;
    in_ctrl = 16'h0101; tick();
    in_ctrl = 16'h0202; tick();
    in_ctrl = 16'h0303; tick();
    chk("mid_fill", 64'(ctrl), 64'h0101_0202_0303);
    stall = 3'b100;
    #1;
    chk("mid_ready_stall", 64'(in_ready), 64'h0);
    reset = 1'b0;
    tick();
    chk("mid_rst_v",    64'(valid), 64'h0);
    chk("mid_rst_ctrl", 64'(ctrl), 64'h0);
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
    stall = 3'b000;
    #1;
    chk("mid_rst_ready2", 64'(in_ready), 64'h1);
    reset = 1'b1;

    // Flush stage 0 while stage 1 stalls: bubble stays held until stall clears
    in_ctrl = 16'h0A0A; tick();
    in_ctrl = 16'h0B0B; tick();
    in_ctrl = 16'h0C0C; tick();
    flush = 3'b001; stall = 3'b010; in_ctrl = 16'h0D0D;
    tick();
    chk("fds1_v",    64'(valid), 64'h2);
    chk("fds1_ctrl", 64'(ctrl), 64'h0000_0B0B_0000);
    flush = 3'b000;
    tick();
    chk("fds2_v", 64'(valid), 64'h2);
    stall = 3'b000;
    tick();
    chk("fds3_v",    64'(valid), 64'h5);
    chk("fds3_ctrl", 64'(ctrl), 64'h0B0B_0000_0D0D);

`ifdef CTRL_PIPE_PERF_EN
    // Counters: clear on reset, then 3 stall[0] cycles and one flush[2]
    in_valid = 1'b0; reset = 1'b0;
    tick(); tick();
    chk("perf_rst_stall",  64'(p_stall),  64'h0);
    chk("perf_rst_bubble", 64'(p_bubble), 64'h0);
    reset = 1'b1; stall = 3'b001;
    tick(); tick(); tick();
    stall = 3'b000; flush = 3'b100;
    tick();
    flush = 3'b000;
    chk("perf_stall",  64'(p_stall),  64'h3);
    chk("perf_bubble", 64'(p_bubble), 64'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
